// File: rtl/usb_string_desc_streamer_if.sv
// EP0 IN packet-buffer stream plus the host's per-packet ACK/retry feedback.
// An item transfers on a rising clk edge where out_valid and out_ready are both high;
// once out_valid rises, out_data/out_last/out_empty hold steady until that transfer.
interface usb_string_desc_streamer_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       out_empty;
   logic       pkt_ack;
   logic       pkt_retry;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      output out_empty,
      input  out_ready,
      input  pkt_ack,
      input  pkt_retry
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      input  out_empty,
      output out_ready,
      output pkt_ack,
      output pkt_retry
   );
endinterface

// File: rtl/usb_string_desc_streamer.sv
// GET_DESCRIPTOR(STRING) data stage: reads the string ROM and streams the descriptor,
// truncated to wLength, into the EP0 IN buffer in max-packet chunks with ACK/retry and ZLP.
module usb_string_desc_streamer #(
   parameter int MAX_PACKET_SIZE = 32,
   parameter int NUM_DESCS       = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  setup_index,
   input  logic [15:0] setup_wlength,
   input  logic        abort,
   output logic [7:0]  str_index,
   output logic [7:0]  rom_addr,
   input  logic [7:0]  rom_length,
   input  logic [7:0]  rom_data,
   usb_string_desc_streamer_if.master bus,
   output logic        busy,
   output logic        done,
   output logic        stall,
   output logic [2:0]  dbg_state
);

   localparam int CW = $clog2(MAX_PACKET_SIZE) + 1;
   localparam logic [CW-1:0] MPS_M1   = CW'(MAX_PACKET_SIZE - 1);
   localparam logic [CW-1:0] MPS_FULL = CW'(MAX_PACKET_SIZE);
   localparam logic [7:0]    NUM_DESCS_B = 8'(NUM_DESCS);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_SEND     = 3'd2,
      S_ZLP      = 3'd3,
      S_WAIT_ACK = 3'd4,
      S_DONE     = 3'd5,
      S_STALL    = 3'd6
   } state_t;

   state_t          state, state_n;
   logic [7:0]      str_index_q, str_index_n;
   logic [15:0]     wlength_q, wlength_n;
   logic [15:0]     total, total_n;
   logic [15:0]     remain, remain_n;
   logic [7:0]      byte_ptr, byte_ptr_n;
   logic [CW-1:0]   pkt_cnt, pkt_cnt_n;
   logic [7:0]      pkt_start_ptr, pkt_start_ptr_n;
   logic [15:0]     pkt_start_remain, pkt_start_remain_n;
   logic            zlp_sent, zlp_sent_n;

   logic [7:0]      out_data;
   logic            out_valid;
   logic            out_last;
   logic            out_empty;
   logic [15:0]     len_ext;
   logic [15:0]     clipped;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= S_IDLE;
         str_index_q      <= '0;
         wlength_q        <= '0;
         total            <= '0;
         remain           <= '0;
         byte_ptr         <= '0;
         pkt_cnt          <= '0;
         pkt_start_ptr    <= '0;
         pkt_start_remain <= '0;
         zlp_sent         <= 1'b0;
      end else begin
         state            <= state_n;
         str_index_q      <= str_index_n;
         wlength_q        <= wlength_n;
         total            <= total_n;
         remain           <= remain_n;
         byte_ptr         <= byte_ptr_n;
         pkt_cnt          <= pkt_cnt_n;
         pkt_start_ptr    <= pkt_start_ptr_n;
         pkt_start_remain <= pkt_start_remain_n;
         zlp_sent         <= zlp_sent_n;
      end
   end

   // Descriptor length clipped to the host's wLength.
   assign len_ext = {8'h00, rom_length};
   assign clipped = (len_ext < wlength_q) ? len_ext : wlength_q;

   always_comb begin
      state_n            = state;
      str_index_n        = str_index_q;
      wlength_n          = wlength_q;
      total_n            = total;
      remain_n           = remain;
      byte_ptr_n         = byte_ptr;
      pkt_cnt_n          = pkt_cnt;
      pkt_start_ptr_n    = pkt_start_ptr;
      pkt_start_remain_n = pkt_start_remain;
      zlp_sent_n         = zlp_sent;
      out_data           = 8'h00;
      out_valid          = 1'b0;
      out_last           = 1'b0;
      out_empty          = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               str_index_n = setup_index;
               wlength_n   = setup_wlength;
               state_n     = S_LOAD;
            end
         end
         S_LOAD: begin
            if (str_index_q >= NUM_DESCS_B) begin
               state_n = S_STALL;
            end else begin
               total_n            = clipped;
               remain_n           = clipped;
               byte_ptr_n         = 8'h00;
               pkt_cnt_n          = '0;
               pkt_start_ptr_n    = 8'h00;
               pkt_start_remain_n = clipped;
               zlp_sent_n         = 1'b0;
               state_n            = (clipped == 16'd0) ? S_ZLP : S_SEND;
            end
         end
         S_SEND: begin
            out_valid = 1'b1;
            out_data  = rom_data;
            out_last  = (pkt_cnt == MPS_M1) || (remain == 16'd1);
            if (bus.out_ready) begin
               byte_ptr_n = byte_ptr + 8'd1;
               remain_n   = remain - 16'd1;
               pkt_cnt_n  = pkt_cnt + CW'(1);
               if (out_last) state_n = S_WAIT_ACK;
            end
         end
         S_ZLP: begin
            out_valid = 1'b1;
            out_last  = 1'b1;
            out_empty = 1'b1;
            if (bus.out_ready) begin
               zlp_sent_n = 1'b1;
               state_n    = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (bus.pkt_ack) begin
               pkt_start_ptr_n    = byte_ptr;
               pkt_start_remain_n = remain;
               if (remain != 16'd0) begin
                  pkt_cnt_n = '0;
                  state_n   = S_SEND;
               end else if ((pkt_cnt == MPS_FULL) && (total < wlength_q) && !zlp_sent) begin
                  // Full final packet on a short transfer: host needs a ZLP to end the stage.
                  pkt_cnt_n = '0;
                  state_n   = S_ZLP;
               end else begin
                  state_n = S_DONE;
               end
            end else if (bus.pkt_retry) begin
               byte_ptr_n = pkt_start_ptr;
               remain_n   = pkt_start_remain;
               pkt_cnt_n  = '0;
               if (zlp_sent) begin
                  zlp_sent_n = 1'b0;
                  state_n    = S_ZLP;
               end else begin
                  state_n = S_SEND;
               end
            end
         end
         S_DONE:  state_n = S_IDLE;
         S_STALL: state_n = S_STALL;
         default: state_n = S_IDLE;
      endcase

      // Abort discards the transfer entirely so the next request starts clean.
      if (abort) begin
         state_n            = S_IDLE;
         str_index_n        = '0;
         wlength_n          = '0;
         total_n            = '0;
         remain_n           = '0;
         byte_ptr_n         = '0;
         pkt_cnt_n          = '0;
         pkt_start_ptr_n    = '0;
         pkt_start_remain_n = '0;
         zlp_sent_n         = 1'b0;
      end
   end

   assign str_index     = str_index_q;
   assign rom_addr      = byte_ptr;
   assign bus.out_data  = out_data;
   assign bus.out_valid = out_valid;
   assign bus.out_last  = out_last;
   assign bus.out_empty = out_empty;
   assign busy          = (state != S_IDLE);
   assign done          = (state == S_DONE);
   assign stall         = (state == S_STALL);
   assign dbg_state     = state;

endmodule

// File: tb/tb_usb_string_desc_streamer.sv
// Bench for usb_string_desc_streamer: three instances (MPS 32/8/4) share one driver,
// a ROM model, and a scoreboard monitor on whichever instance is selected.
module tb_usb_string_desc_streamer;

   localparam logic [111:0] STR1 = "Streamer Rev A";
   localparam logic [95:0]  STR2 = "HW SN 000123";

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int          sel = 0;
   logic        start_s = 1'b0;
   logic        abort_s = 1'b0;
   logic        ready_s = 1'b1;
   logic        ack_s = 1'b0;
   logic        retry_s = 1'b0;
   logic [7:0]  index_s = 8'h00;
   logic [15:0] wlen_s = 16'h0000;
   bit          rnd_ready = 1'b0;

   int n_checks = 0;
   int n_fail = 0;
   int xfers = 0;
   int lasts = 0;
   logic [9:0] exp_q[$];

   usb_string_desc_streamer_if bus0();
   usb_string_desc_streamer_if bus1();
   usb_string_desc_streamer_if bus2();

   logic [7:0] str_index_w [3];
   logic [7:0] rom_addr_w [3];
   logic [7:0] rom_length_w [3];
   logic [7:0] rom_data_w [3];
   logic       busy_w [3];
   logic       done_w [3];
   logic       stall_w [3];
   logic [2:0] dbg_w [3];

   function automatic int desc_len(input logic [7:0] idx);
      case (idx)
         8'd0:    return 4;
         8'd1:    return 30;
         8'd2:    return 26;
         default: return 0;
      endcase
   endfunction

   function automatic logic [7:0] rom_byte(input logic [7:0] idx, input logic [7:0] addr);
      logic [7:0] r;
      int k;
      r = 8'h00;
      k = (int'(addr) - 2) / 2;
      case (idx)
         8'd0: begin
            case (addr)
               8'd0:    r = 8'h04;
               8'd1:    r = 8'h03;
               8'd2:    r = 8'h09;
               8'd3:    r = 8'h04;
               default: r = 8'h00;
            endcase
         end
         8'd1: begin
            if (addr == 8'd0) r = 8'h1E;
            else if (addr == 8'd1) r = 8'h03;
            else if (addr < 8'd30 && !addr[0]) r = STR1[8*(13-k) +: 8];
         end
         8'd2: begin
            if (addr == 8'd0) r = 8'h1A;
            else if (addr == 8'd1) r = 8'h03;
            else if (addr < 8'd26 && !addr[0]) r = STR2[8*(11-k) +: 8];
         end
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_rom
      assign rom_length_w[g] = 8'(desc_len(str_index_w[g]));
      assign rom_data_w[g]   = rom_byte(str_index_w[g], rom_addr_w[g]);
   end

   assign bus0.out_ready = ready_s && (sel == 0);
   assign bus0.pkt_ack   = ack_s && (sel == 0);
   assign bus0.pkt_retry = retry_s && (sel == 0);
   assign bus1.out_ready = ready_s && (sel == 1);
   assign bus1.pkt_ack   = ack_s && (sel == 1);
   assign bus1.pkt_retry = retry_s && (sel == 1);
   assign bus2.out_ready = ready_s && (sel == 2);
   assign bus2.pkt_ack   = ack_s && (sel == 2);
   assign bus2.pkt_retry = retry_s && (sel == 2);

   usb_string_desc_streamer #(.MAX_PACKET_SIZE(32), .NUM_DESCS(3)) dut0 (
      .clk(clk), .reset_n(reset_n), .start(start_s && (sel == 0)),
      .setup_index(index_s), .setup_wlength(wlen_s), .abort(abort_s && (sel == 0)),
      .str_index(str_index_w[0]), .rom_addr(rom_addr_w[0]),
      .rom_length(rom_length_w[0]), .rom_data(rom_data_w[0]), .bus(bus0),
      .busy(busy_w[0]), .done(done_w[0]), .stall(stall_w[0]), .dbg_state(dbg_w[0])
   );

   usb_string_desc_streamer #(.MAX_PACKET_SIZE(8), .NUM_DESCS(3)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start_s && (sel == 1)),
      .setup_index(index_s), .setup_wlength(wlen_s), .abort(abort_s && (sel == 1)),
      .str_index(str_index_w[1]), .rom_addr(rom_addr_w[1]),
      .rom_length(rom_length_w[1]), .rom_data(rom_data_w[1]), .bus(bus1),
      .busy(busy_w[1]), .done(done_w[1]), .stall(stall_w[1]), .dbg_state(dbg_w[1])
   );

   usb_string_desc_streamer #(.MAX_PACKET_SIZE(4), .NUM_DESCS(3)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(start_s && (sel == 2)),
      .setup_index(index_s), .setup_wlength(wlen_s), .abort(abort_s && (sel == 2)),
      .str_index(str_index_w[2]), .rom_addr(rom_addr_w[2]),
      .rom_length(rom_length_w[2]), .rom_data(rom_data_w[2]), .bus(bus2),
      .busy(busy_w[2]), .done(done_w[2]), .stall(stall_w[2]), .dbg_state(dbg_w[2])
   );

   logic [7:0] m_data, m_str_index, m_rom_addr;
   logic       m_valid, m_ready, m_last, m_empty, m_busy, m_done, m_stall;
   logic [2:0] m_dbg;

   always_comb begin
      m_data = bus0.out_data;   m_valid = bus0.out_valid; m_ready = bus0.out_ready;
      m_last = bus0.out_last;   m_empty = bus0.out_empty;
      case (sel)
         1: begin
            m_data = bus1.out_data;  m_valid = bus1.out_valid; m_ready = bus1.out_ready;
            m_last = bus1.out_last;  m_empty = bus1.out_empty;
         end
         2: begin
            m_data = bus2.out_data;  m_valid = bus2.out_valid; m_ready = bus2.out_ready;
            m_last = bus2.out_last;  m_empty = bus2.out_empty;
         end
         default: ;
      endcase
      m_str_index = str_index_w[sel];
      m_rom_addr  = rom_addr_w[sel];
      m_busy      = busy_w[sel];
      m_done      = done_w[sel];
      m_stall     = stall_w[sel];
      m_dbg       = dbg_w[sel];
   end

   // Scoreboard monitor: every accepted item is popped and compared.
   always @(negedge clk) begin
      if (m_valid && m_ready) begin
         logic [9:0] got, exp;
         got = {m_empty, m_last, (m_empty ? 8'h00 : m_data)};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL item_unexpected got=%h expected=none", got);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               n_fail++;
               $display("FAIL item_compare got=%h expected=%h (empty,last,data)", got, exp);
            end
         end
         xfers++;
         if (m_last) lasts++;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         ready_s = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] idx, input logic [15:0] wlen);
      index_s = idx;
      wlen_s  = wlen;
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
   endtask

   task automatic wait_last(input int target);
      int k;
      k = 0;
      while (lasts < target && k < 500) begin
         tick();
         k++;
      end
      if (lasts < target) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_last timeout got=%0d expected=%0d", lasts, target);
      end
   endtask

   task automatic pulse_ack(input bit with_retry);
      ack_s   = 1'b1;
      retry_s = with_retry;
      tick();
      ack_s   = 1'b0;
      retry_s = 1'b0;
   endtask

   task automatic pulse_retry();
      retry_s = 1'b1;
      tick();
      retry_s = 1'b0;
   endtask

   task automatic build_expected(input logic [7:0] idx, input logic [15:0] wlen, input int mps,
                                 input int retry_p, output int n);
      int total, off, c, len;
      int poff[$];
      int plen[$];
      len = desc_len(idx);
      total = (len < int'(wlen)) ? len : int'(wlen);
      off = 0;
      while (off < total) begin
         c = (total - off < mps) ? total - off : mps;
         poff.push_back(off);
         plen.push_back(c);
         off += c;
      end
      if (total == 0 || (total % mps == 0 && total < int'(wlen))) begin
         poff.push_back(total);
         plen.push_back(0);
      end
      n = poff.size();
      for (int p = 0; p < n; p++) begin
         for (int r = 0; r < ((p == retry_p) ? 2 : 1); r++) begin
            if (plen[p] == 0) exp_q.push_back({2'b11, 8'h00});
            else
               for (int j = 0; j < plen[p]; j++)
                  exp_q.push_back({1'b0, (j == plen[p] - 1), rom_byte(idx, 8'(poff[p] + j))});
         end
      end
   endtask

   task automatic run_request(input int s, input logic [7:0] idx, input logic [15:0] wlen,
                              input int mps, input int retry_p, input bit rnd, input bit ack_retry);
      int n, target, p;
      bit retried;
      sel = s;
      rnd_ready = rnd;
      build_expected(idx, wlen, mps, retry_p, n);
      target = lasts;
      p = 0;
      retried = 1'b0;
      do_start(idx, wlen);
      while (p < n) begin
         target++;
         wait_last(target);
         check("wait_ack_bus_idle", {31'd0, m_valid}, 32'd0);
         repeat ($urandom_range(0, 2)) tick();
         if (p == retry_p && !retried) begin
            retried = 1'b1;
            pulse_retry();
         end else begin
            pulse_ack(ack_retry);
            p++;
         end
      end
      check("done_pulse", {31'd0, m_done}, 32'd1);
      tick();
      check("done_clear_idle", {30'd0, m_done, m_busy}, 32'd0);
      check("queue_drained", exp_q.size(), 32'd0);
      rnd_ready = 1'b0;
   endtask

   initial begin
      int n, base, k, target;
      bit valid_seen;

      repeat (2) @(posedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check("reset_outputs", {2'd0, m_valid, m_last, m_empty, m_busy, m_done, m_stall,
                                 m_data, m_str_index, m_rom_addr}, 32'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      run_request(0, 8'd1, 16'd255, 32, -1, 1'b0, 1'b0);
      run_request(0, 8'd0, 16'd2, 32, -1, 1'b0, 1'b0);
      run_request(1, 8'd2, 16'd255, 8, 1, 1'b1, 1'b0);
      run_request(2, 8'd0, 16'd64, 4, -1, 1'b0, 1'b0);
      run_request(2, 8'd0, 16'd64, 4, 1, 1'b1, 1'b0);
      run_request(2, 8'd0, 16'd4, 4, -1, 1'b0, 1'b1);
      run_request(0, 8'd1, 16'd0, 32, -1, 1'b0, 1'b0);
      run_request(1, 8'd2, 16'd16, 8, -1, 1'b1, 1'b0);

      // Invalid index: stall appears two cycles after start and holds until abort.
      sel = 0;
      do_start(8'd5, 16'd255);
      check("stall_not_yet", {30'd0, m_stall, m_busy}, 32'd1);
      tick();
      check("stall_asserted", {30'd0, m_stall, m_busy}, 32'd3);
      valid_seen = 1'b0;
      do_start(8'd1, 16'd255);
      for (int i = 0; i < 6; i++) begin
         tick();
         valid_seen |= m_valid;
      end
      check("stall_held", {31'd0, m_stall}, 32'd1);
      check("stall_no_valid", {31'd0, valid_seen}, 32'd0);
      abort_s = 1'b1;
      tick();
      abort_s = 1'b0;
      check("stall_abort_clear", {30'd0, m_stall, m_busy}, 32'd0);

      // Abort in the middle of a packet.
      sel = 0;
      build_expected(8'd1, 16'd255, 32, -1, n);
      base = xfers;
      do_start(8'd1, 16'd255);
      k = 0;
      while (xfers - base < 5 && k < 100) begin
         tick();
         k++;
      end
      check("abort_reached_byte5", {31'd0, (xfers - base >= 5)}, 32'd1);
      abort_s = 1'b1;
      tick();
      abort_s = 1'b0;
      check("abort_idle", {21'd0, m_valid, m_busy, m_stall, m_rom_addr}, 32'd0);
      exp_q.delete();
      tick();

      // Asynchronous reset while waiting for the host ACK.
      build_expected(8'd0, 16'd2, 32, -1, n);
      target = lasts + 1;
      do_start(8'd0, 16'd2);
      wait_last(target);
      check("in_wait_ack", {29'd0, m_dbg}, 32'd4);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset_outputs", {2'd0, m_valid, m_last, m_empty, m_busy, m_done, m_stall,
                                    m_data, m_str_index, m_rom_addr}, 32'd0);
      check("queue_drained_pre_reset", exp_q.size(), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      run_request(0, 8'd1, 16'd255, 32, -1, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
